// File: rtl/phase3_monitor.sv
// phase3_monitor
// ---------------------------------------------------------------------------
// Checks the three-phase clock generator from downstream. PHI_IN is the
// one-cold phase vector; a healthy generator presents 011 -> 101 -> 110 ->
// 011 (rotate right), one step per CLK_IN edge. The monitor acquires lock
// after LOCK_COUNT consecutive good transitions. While locked it counts
// completed rotations. It latches the first sequence fault.
//
// Optional feature (compile-time macro PHASE3_MON_OVERLAP_EN):
//   Adds input CLK_PH_IN[3:1], the non-overlapping NOR-ring clocks. More than
//   one of these bits high on an edge is a bad sample with code 4.
//
// Parameters:
//   LOCK_COUNT  good transitions needed to lock (1..255)
//   CNT_W       width of ERR_CNT and CYCLE_CNT
//
// Ports:
//   CLK_IN     clock shared with the phase generator
//   RST        synchronous, active-high reset
//   EN         monitor enable; low returns the FSM to IDLE
//   CLR        single-cycle pulse; clears FAULT, ERR_CODE and ERR_CNT
//   PHI_IN     one-cold phase vector under test
//   CLK_PH_IN  non-overlap clocks (only with PHASE3_MON_OVERLAP_EN)
//   LOCKED     sequence verified and running
//   FAULT      sticky: a sequence error occurred while locked
//   ERR_CODE   first error since CLR: 0 none, 1 illegal, 2 stall,
//              3 wrong order, 4 overlap
//   ERR_CNT    saturating error count
//   CYCLE_CNT  completed rotations while locked (wraps)
//   state      FSM state: 0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 FAULTED
//
// All outputs are registered and reflect the sample taken on the same edge.
// ---------------------------------------------------------------------------
module phase3_monitor #(
  parameter int LOCK_COUNT = 6,
  parameter int CNT_W      = 8
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [3:1]       PHI_IN,
`ifdef PHASE3_MON_OVERLAP_EN
  input  logic [3:1]       CLK_PH_IN,
`endif
  output logic             LOCKED,
  output logic             FAULT,
  output logic [2:0]       ERR_CODE,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic [1:0]       state
);

  if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock_count
    $error("phase3_monitor: LOCK_COUNT must be in 1..255");
  end

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULTED = 2'd3;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL = 3'd1;
  localparam logic [2:0] CODE_STALL   = 3'd2;
  localparam logic [2:0] CODE_ORDER   = 3'd3;
  localparam logic [2:0] CODE_OVERLAP = 3'd4;

  logic [3:1] phi_q;
  logic       prev_v;
  logic [7:0] good_cnt;

  logic       legal;
  logic       overlap;
  logic [3:1] ror_q;
  logic [2:0] code;
  logic       bad;

  // Expected successor of the previous sample.
  assign ror_q = {phi_q[1], phi_q[3:2]};

`ifdef PHASE3_MON_OVERLAP_EN
  assign overlap = (CLK_PH_IN[3] & CLK_PH_IN[2]) |
                   (CLK_PH_IN[3] & CLK_PH_IN[1]) |
                   (CLK_PH_IN[2] & CLK_PH_IN[1]);
`else
  assign overlap = 1'b0;
`endif

  // The case items only match fully-known values, so an X on PHI_IN
  // falls into the default branch and classifies as illegal.
  always_comb begin
    legal = 1'b0;
    case (PHI_IN)
      3'b011, 3'b101, 3'b110: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  // Classification in priority order.
  always_comb begin
    code = CODE_NONE;
    if (!legal)                 code = CODE_ILLEGAL;
    else if (overlap)           code = CODE_OVERLAP;
    else if (PHI_IN == phi_q)   code = CODE_STALL;
    else if (PHI_IN != ror_q)   code = CODE_ORDER;
  end

  // With no valid previous sample there is nothing to compare against.
  assign bad = prev_v && (code != CODE_NONE);

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state     <= ST_IDLE;
      phi_q     <= 3'b111;
      prev_v    <= 1'b0;
      good_cnt  <= 8'd0;
      LOCKED    <= 1'b0;
      FAULT     <= 1'b0;
      ERR_CODE  <= CODE_NONE;
      ERR_CNT   <= '0;
      CYCLE_CNT <= '0;
    end else if (!EN) begin
      // Disabled: drop lock and sample history, keep the fault record.
      state    <= ST_IDLE;
      prev_v   <= 1'b0;
      good_cnt <= 8'd0;
      LOCKED   <= 1'b0;
      if (CLR) begin
        FAULT    <= 1'b0;
        ERR_CODE <= CODE_NONE;
        ERR_CNT  <= '0;
      end
    end else begin
      phi_q  <= PHI_IN;
      prev_v <= 1'b1;

      // Clearing happens first; the LOCKED branch only records a new
      // error when CLR is low, so CLR wins over a same-cycle error.
      if (CLR) begin
        FAULT    <= 1'b0;
        ERR_CODE <= CODE_NONE;
        ERR_CNT  <= '0;
      end

      case (state)
        ST_IDLE: begin
          state    <= ST_ACQUIRE;
          good_cnt <= 8'd0;
        end

        ST_ACQUIRE: begin
          // Acquisition errors are expected and are not recorded.
          if (bad) begin
            good_cnt <= 8'd0;
          end else begin
            good_cnt <= good_cnt + 8'd1;
            if (good_cnt == LOCK_TGT - 8'd1) begin
              state  <= ST_LOCKED;
              LOCKED <= 1'b1;
            end
          end
        end

        ST_LOCKED: begin
          if (bad) begin
            good_cnt <= 8'd0;
            if (!CLR) begin
              state  <= ST_FAULTED;
              LOCKED <= 1'b0;
              FAULT  <= 1'b1;
              if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
              if (ERR_CODE == CODE_NONE) ERR_CODE <= code;
            end
          end else if (PHI_IN == 3'b011) begin
            CYCLE_CNT <= CYCLE_CNT + 1'b1;
          end
        end

        ST_FAULTED: begin
          // Outputs hold; only CLR leaves this state.
          if (CLR) begin
            state    <= ST_ACQUIRE;
            good_cnt <= 8'd0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          good_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase3_monitor.sv
// tb_phase3_monitor
// ---------------------------------------------------------------------------
// Directed bench for phase3_monitor (LOCK_COUNT=6, CNT_W=4). The driver
// applies one vector per cycle at the falling edge and pushes the
// hand-derived expected outputs for that vector into exp_q. A separate
// monitor pops one entry after each rising edge and compares it with the
// DUT outputs. Define PHASE3_MON_OVERLAP_EN to also run the overlap case.
// ---------------------------------------------------------------------------
module tb_phase3_monitor;

  localparam int CW = 4;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_A = 2'd1;
  localparam logic [1:0] S_L = 2'd2;
  localparam logic [1:0] S_F = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic          clr;
  logic [3:1]    phi;
`ifdef PHASE3_MON_OVERLAP_EN
  logic [3:1]    clk_ph;
  logic [3:1]    clk_ph_nxt;
`endif
  logic          locked;
  logic          fault;
  logic [2:0]    err_code;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] cycle_cnt;
  logic [1:0]    state;

  phase3_monitor #(.LOCK_COUNT(6), .CNT_W(CW)) dut (
    .CLK_IN    (clk),
    .RST       (rst),
    .EN        (en),
    .CLR       (clr),
    .PHI_IN    (phi),
`ifdef PHASE3_MON_OVERLAP_EN
    .CLK_PH_IN (clk_ph),
`endif
    .LOCKED    (locked),
    .FAULT     (fault),
    .ERR_CODE  (err_code),
    .ERR_CNT   (err_cnt),
    .CYCLE_CNT (cycle_cnt),
    .state     (state)
  );

  // ---------------- scoreboard ----------------
  // entry = {state, locked, fault, err_code, err_cnt, cycle_cnt}
  localparam int EW = 2 + 1 + 1 + 3 + CW + CW;
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  // Expected outputs after the next applied vector, set by hand in main.
  logic [1:0]    x_st;
  logic          x_locked;
  logic          x_fault;
  logic [2:0]    x_code;
  logic [CW-1:0] x_err;
  logic [CW-1:0] x_cyc;
  logic [3:1]    cur;

  logic [EW-1:0] m_exp;
  logic [EW-1:0] m_act;
  string         m_name;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      m_act  = {state, locked, fault, err_code, err_cnt, cycle_cnt};
      n_vec++;
      if (m_act !== m_exp) begin
        n_err++;
        $display("FAIL %s: got st=%0d lk=%0b flt=%0b code=%0d err=%0d cyc=%0d, want st=%0d lk=%0b flt=%0b code=%0d err=%0d cyc=%0d",
                 m_name, state, locked, fault, err_code, err_cnt, cycle_cnt,
                 m_exp[EW-1 -: 2], m_exp[EW-3], m_exp[EW-4], m_exp[EW-5 -: 3],
                 m_exp[2*CW-1 -: CW], m_exp[CW-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [3:1] nxt(input logic [3:1] p);
    case (p)
      3'b011:  nxt = 3'b101;
      3'b101:  nxt = 3'b110;
      default: nxt = 3'b011;
    endcase
  endfunction

  task automatic drive(input logic rst_v, input logic en_v, input logic clr_v,
                       input logic [3:1] phi_v, input string nm);
    @(negedge clk);
    rst = rst_v;
    en  = en_v;
    clr = clr_v;
    phi = phi_v;
`ifdef PHASE3_MON_OVERLAP_EN
    clk_ph = clk_ph_nxt;
`endif
    cur = phi_v;
    exp_q.push_back({x_st, x_locked, x_fault, x_code, x_err, x_cyc});
    name_q.push_back(nm);
  endtask

  // From ACQUIRE with a valid previous sample: six good transitions,
  // lock is reported after the sixth.
  task automatic lock_run(input string nm);
    for (int i = 1; i <= 6; i++) begin
      x_st     = (i == 6) ? S_L : S_A;
      x_locked = (i == 6);
      drive(1'b0, 1'b1, 1'b0, nxt(cur), nm);
    end
  endtask

  // Good samples while locked; a completed rotation is each 011.
  task automatic rotate(input int n, input string nm);
    logic [3:1] p;
    for (int i = 0; i < n; i++) begin
      p = nxt(cur);
      if (p == 3'b011) x_cyc = x_cyc + 1'b1;
      drive(1'b0, 1'b1, 1'b0, p, nm);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; phi = 3'b111; cur = 3'b111;
`ifdef PHASE3_MON_OVERLAP_EN
    clk_ph = 3'b100; clk_ph_nxt = 3'b100;
`endif
    x_st = S_I; x_locked = 1'b0; x_fault = 1'b0; x_code = 3'd0;
    x_err = '0; x_cyc = '0;

    // reset for two cycles
    drive(1'b1, 1'b0, 1'b0, 3'b011, "reset");
    drive(1'b1, 1'b0, 1'b0, 3'b011, "reset");

    // 1: first sample only loads, lock after 6 good transitions
    x_st = S_A;
    drive(1'b0, 1'b1, 1'b0, 3'b011, "t1_load");
    lock_run("t1_lock");

    // 2: stall while locked
    rotate(4, "t2_rot");                          // 101 110 011 101, cyc=1
    x_st = S_F; x_locked = 1'b0; x_fault = 1'b1; x_code = 3'd2; x_err = 4'd1;
    drive(1'b0, 1'b1, 1'b0, 3'b101, "t2_stall");
    drive(1'b0, 1'b1, 1'b0, 3'b110, "t2_hold");
    x_st = S_A; x_fault = 1'b0; x_code = 3'd0; x_err = 4'd0;
    drive(1'b0, 1'b1, 1'b1, 3'b011, "t2_clr");
    lock_run("t2_relock");

    // 3: illegal pattern, then no second count while faulted
    x_st = S_F; x_locked = 1'b0; x_fault = 1'b1; x_code = 3'd1; x_err = 4'd1;
    drive(1'b0, 1'b1, 1'b0, 3'b001, "t3_illegal");
    drive(1'b0, 1'b1, 1'b0, 3'b011, "t3_hold");
    drive(1'b0, 1'b1, 1'b0, 3'b110, "t3_hold_order");
    x_st = S_A; x_fault = 1'b0; x_code = 3'd0; x_err = 4'd0;
    drive(1'b0, 1'b1, 1'b1, 3'b011, "t3_clr");
    lock_run("t3_relock");

    // 4: 30 samples -> 10 rotations (cyc 1 -> 11), 15 more wraps to 0
    rotate(30, "t4_rot");
    rotate(15, "t4_wrap");

    // 4b: repeated wrong-order faults via EN toggle, ERR_CNT saturates
    for (int k = 0; k < 18; k++) begin
      x_st = S_F; x_locked = 1'b0; x_fault = 1'b1; x_code = 3'd3;
      if (x_err != 4'hF) x_err = x_err + 1'b1;
      drive(1'b0, 1'b1, 1'b0, 3'b110, "t4_err");
      x_st = S_I;
      drive(1'b0, 1'b0, 1'b0, 3'b110, "t4_idle");
      x_st = S_A;
      drive(1'b0, 1'b1, 1'b0, 3'b011, "t4_load");
      lock_run("t4_relock");
    end

    // 5: CLR on the same edge as a wrong-order sample while locked
    x_st = S_F; x_locked = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 3'b110, "t5_err");      // err stays 15
    x_st = S_I;
    drive(1'b0, 1'b0, 1'b0, 3'b110, "t5_idle");
    x_st = S_A;
    drive(1'b0, 1'b1, 1'b0, 3'b011, "t5_load");
    lock_run("t5_lock");
    x_fault = 1'b0; x_code = 3'd0; x_err = 4'd0;   // stays LOCKED
    drive(1'b0, 1'b1, 1'b1, 3'b110, "t5_clr_err");
    x_cyc = x_cyc + 1'b1;
    drive(1'b0, 1'b1, 1'b0, 3'b011, "t5_good");
    // EN low mid-lock: lock drops, counts held
    x_st = S_I; x_locked = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b101, "t5_en_off");
    x_st = S_A;
    drive(1'b0, 1'b1, 1'b0, 3'b101, "t5_load2");
    lock_run("t5_relock");
    // RST mid-lock clears everything
    x_st = S_I; x_locked = 1'b0; x_fault = 1'b0; x_code = 3'd0;
    x_err = 4'd0; x_cyc = 4'd0;
    drive(1'b1, 1'b1, 1'b0, nxt(cur), "t5_rst");
    x_st = S_A;
    drive(1'b0, 1'b1, 1'b0, 3'b011, "t5_load3");
    lock_run("t5_relock2");
    // all-ones has no zero: illegal
    x_st = S_F; x_locked = 1'b0; x_fault = 1'b1; x_code = 3'd1; x_err = 4'd1;
    drive(1'b0, 1'b1, 1'b0, 3'b111, "t5_all_ones");

`ifdef PHASE3_MON_OVERLAP_EN
    // 6: overlapping non-overlap clocks while locked
    x_st = S_A; x_fault = 1'b0; x_code = 3'd0; x_err = 4'd0;
    drive(1'b0, 1'b1, 1'b1, 3'b011, "t6_clr");
    lock_run("t6_lock");
    clk_ph_nxt = 3'b011;
    x_st = S_F; x_locked = 1'b0; x_fault = 1'b1; x_code = 3'd4; x_err = 4'd1;
    drive(1'b0, 1'b1, 1'b0, nxt(cur), "t6_overlap");
    clk_ph_nxt = 3'b100;
    drive(1'b0, 1'b1, 1'b0, nxt(cur), "t6_hold");
`endif

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
